bus_dma: RTL and testbench



---
 rtl/bus_dma.sv | 177 +++++++++++++++++
 tb/tb_bus_dma.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma.sv
// bus_dma: bus initiator that copies a block of words over the shared
// tristate sysbus using the MAR/MDR/CS/R_NW protocol of the basic processor.
// The CPU supplies source, destination and length, grants the bus, and this
// block runs one read and one write bus cycle for each word.
//
// Ports
//   clock, n_reset        : system clock, asynchronous active-low reset
//   start                 : one-cycle request, sampled only in IDLE
//   src, dst, len         : first source/destination address, word count
//   bus_gnt / bus_req     : bus grant from the CPU / bus request to the CPU
//   busy, done            : busy outside IDLE, one-cycle pulse at completion
//   load_MAR, load_MDR,
//   MDR_bus, CS, R_NW     : bus control strobes (R_NW: 1 = read, 0 = write)
//   sysbus                : shared bus, driven only while an address or
//                           data word is being placed on it
//   state_dbg_o           : current state encoding, for observation only
//
// Handshake: start is a request that is accepted only when the block is in
// IDLE; a start in any other state is dropped. bus_req is a request that
// stays high from REQ through the last bus cycle of every word. bus_gnt is
// sampled only in REQ and on the final cycle of a word. Once a word has
// started, its six bus cycles always complete whatever bus_gnt does.
module bus_dma #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                     clock,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic [WORD_W-OP_W-1:0]   src,
  input  logic [WORD_W-OP_W-1:0]   dst,
  input  logic [WORD_W-OP_W-1:0]   len,
  input  logic                     bus_gnt,
  output logic                     bus_req,
  output logic                     busy,
  output logic                     done,
  output logic                     load_MAR,
  output logic                     load_MDR,
  output logic                     MDR_bus,
  output logic                     CS,
  output logic                     R_NW,
  inout  wire  [WORD_W-1:0]        sysbus,
  output logic [3:0]               state_dbg_o
);

  localparam int A_W = WORD_W - OP_W;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_REQ    = 4'd1;
  localparam logic [3:0] S_RD_MAR = 4'd2;
  localparam logic [3:0] S_RD_CS  = 4'd3;
  localparam logic [3:0] S_RD_BUS = 4'd4;
  localparam logic [3:0] S_WR_MAR = 4'd5;
  localparam logic [3:0] S_WR_MDR = 4'd6;
  localparam logic [3:0] S_WR_CS  = 4'd7;
  localparam logic [3:0] S_FIN    = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [A_W-1:0]    src_q, src_d;
  logic [A_W-1:0]    dst_q, dst_d;
  logic [A_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0] buf_q, buf_d;

  logic              drv_en;
  logic [WORD_W-1:0] drv_val;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          cnt_d   = len;
          state_d = (len == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ:    if (bus_gnt) state_d = S_RD_MAR;
      S_RD_MAR: state_d = S_RD_CS;
      S_RD_CS:  state_d = S_RD_BUS;
      S_RD_BUS: begin
        // The responder drives its MDR onto the bus during this cycle.
        buf_d   = sysbus;
        state_d = S_WR_MAR;
      end
      S_WR_MAR: state_d = S_WR_MDR;
      S_WR_MDR: state_d = S_WR_CS;
      S_WR_CS: begin
        // Addresses wrap naturally at the A_W-bit boundary.
        src_d = src_q + A_W'(1);
        dst_d = dst_q + A_W'(1);
        cnt_d = cnt_q - A_W'(1);
        if (cnt_q == A_W'(1))  state_d = S_FIN;
        else if (bus_gnt)      state_d = S_RD_MAR;
        else                   state_d = S_REQ;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs depend only on registered state, so reset drops every strobe
  // and releases the bus at once, without waiting for a clock edge.
  always_comb begin
    bus_req  = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    load_MAR = 1'b0;
    load_MDR = 1'b0;
    MDR_bus  = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b1;
    drv_en   = 1'b0;
    drv_val  = '0;
    case (state_q)
      S_REQ:    bus_req = 1'b1;
      S_RD_MAR: begin
        bus_req  = 1'b1;
        load_MAR = 1'b1;
        drv_en   = 1'b1;
        drv_val  = {{OP_W{1'b0}}, src_q};
      end
      S_RD_CS: begin
        bus_req = 1'b1;
        CS      = 1'b1;
      end
      S_RD_BUS: begin
        bus_req = 1'b1;
        MDR_bus = 1'b1;
      end
      S_WR_MAR: begin
        bus_req  = 1'b1;
        load_MAR = 1'b1;
        drv_en   = 1'b1;
        drv_val  = {{OP_W{1'b0}}, dst_q};
      end
      S_WR_MDR: begin
        bus_req  = 1'b1;
        load_MDR = 1'b1;
        drv_en   = 1'b1;
        drv_val  = buf_q;
      end
      S_WR_CS: begin
        bus_req = 1'b1;
        CS      = 1'b1;
        R_NW    = 1'b0;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  assign sysbus      = drv_en ? drv_val : {WORD_W{1'bz}};
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bus_dma.sv
// Bench for bus_dma: a RAM responder on sysbus, a word-level reference model
// of the copy (per-word step counter plus a reference memory), a per-cycle
// compare process and directed plus randomized transfers.
module tb_bus_dma;

  // Clock / reset and DUT signals
  logic       clock = 1'b0;
  logic       n_reset;
  logic       start = 1'b0;
  logic [4:0] src = '0, dst = '0, len = '0;
  logic       bus_gnt = 1'b1;
  logic       bus_req, busy, done, load_MAR, load_MDR, MDR_bus, CS, R_NW;
  wire  [7:0] sysbus;
  logic [3:0] state_dbg;

  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b0;

  always #5 clock = ~clock;

  bus_dma #(.WORD_W(8), .OP_W(3)) dut (
    .clock(clock), .n_reset(n_reset), .start(start),
    .src(src), .dst(dst), .len(len), .bus_gnt(bus_gnt),
    .bus_req(bus_req), .busy(busy), .done(done),
    .load_MAR(load_MAR), .load_MDR(load_MDR), .MDR_bus(MDR_bus),
    .CS(CS), .R_NW(R_NW), .sysbus(sysbus), .state_dbg_o(state_dbg)
  );

  // Responder: RAM with MAR/MDR, plus a preload port for the bench.
  logic [7:0] env_ram [32];
  logic [4:0] env_mar;
  logic [7:0] env_mdr;
  logic       init_we = 1'b0;
  logic [4:0] init_a = '0;
  logic [7:0] init_d = '0;

  // Whenever the bus should be free, the bench drives a random probe value;
  // any stray DUT drive corrupts it and shows up in the compare.
  logic       probe_en = 1'b1;
  logic [7:0] probe_val = 8'h00;

  assign sysbus = MDR_bus ? env_mdr : (probe_en ? probe_val : 8'bz);

  always @(posedge clock) begin
    if (init_we)       env_ram[init_a] <= init_d;
    if (load_MAR)      env_mar <= sysbus[4:0];
    if (load_MDR)      env_mdr <= sysbus;
    if (CS && R_NW)    env_mdr <= env_ram[env_mar];
    if (CS && !R_NW)   env_ram[env_mar] <= env_mdr;
  end

  // Reference model: a transfer is "waiting for grant" or at step 0..5 of a
  // word; a word's copy lands in ref_mem when its sixth cycle ends.
  logic [7:0] ref_mem [32];
  logic       m_act, m_fin, m_wait;
  int         m_step;
  logic [4:0] m_src, m_dst, m_left;
  logic [6:0] e_vec;   // {bus_req,busy,done,load_MAR,load_MDR,MDR_bus,CS}
  logic       e_rnw;
  logic [7:0] e_bus;

  always @(posedge clock or negedge n_reset) begin
    logic w;
    if (!n_reset) begin
      m_act = 1'b0; m_fin = 1'b0; m_wait = 1'b0; m_step = 0;
    end else begin
      if (init_we) ref_mem[init_a] = init_d;
      if (m_fin) m_fin = 1'b0;
      else if (!m_act) begin
        if (start) begin
          m_src = src; m_dst = dst; m_left = len;
          if (len == 5'd0) m_fin = 1'b1;
          else begin m_act = 1'b1; m_wait = 1'b1; end
        end
      end else if (m_wait) begin
        if (bus_gnt) begin m_wait = 1'b0; m_step = 0; end
      end else if (m_step < 5) m_step = m_step + 1;
      else begin
        ref_mem[m_dst] = ref_mem[m_src];
        m_src = m_src + 5'd1;
        m_dst = m_dst + 5'd1;
        m_left = m_left - 5'd1;
        if (m_left == 5'd0) begin m_act = 1'b0; m_fin = 1'b1; end
        else if (bus_gnt) m_step = 0;
        else m_wait = 1'b1;
      end
    end
    w = m_act && !m_wait;
    e_vec <= {m_act, m_act || m_fin, m_fin, w && (m_step == 0 || m_step == 3),
              w && (m_step == 4), w && (m_step == 2), w && (m_step == 1 || m_step == 5)};
    e_rnw <= !(w && m_step == 5);
    probe_en <= !(w && (m_step == 0 || m_step == 2 || m_step == 3 || m_step == 4));
    probe_val <= 8'($urandom);
  end

  always @* begin
    logic w2;
    w2 = m_act && !m_wait;
    if (w2 && m_step == 0)                      e_bus = {3'b000, m_src};
    else if (w2 && m_step == 3)                 e_bus = {3'b000, m_dst};
    else if (w2 && (m_step == 2 || m_step == 4)) e_bus = ref_mem[m_src];
    else                                        e_bus = probe_val;
  end

  // Scoreboard compare, every cycle, away from the active edge.
  always @(negedge clock) begin
    if (n_reset && chk_en) begin
      total++;
      if ({bus_req, busy, done, load_MAR, load_MDR, MDR_bus, CS} !== e_vec) begin
        bad++;
        $display("FAIL outputs t=%0t got %b want %b", $time,
                 {bus_req, busy, done, load_MAR, load_MDR, MDR_bus, CS}, e_vec);
      end
      total++;
      if (sysbus !== e_bus) begin
        bad++;
        $display("FAIL sysbus t=%0t got %h want %h", $time, sysbus, e_bus);
      end
      if (e_vec[0]) begin
        total++;
        if (R_NW !== e_rnw) begin
          bad++;
          $display("FAIL r_nw t=%0t got %b want %b", $time, R_NW, e_rnw);
        end
      end
    end
  end

  // Driver tasks and checks
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic mem_write(input logic [4:0] a, input logic [7:0] d);
    init_we = 1'b1; init_a = a; init_d = d;
    @(negedge clock);
    init_we = 1'b0;
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (env_ram[i] !== ref_mem[i]) begin
        bad++;
        $display("FAIL %s mem[%0d] got %h want %h", name, i, env_ram[i], ref_mem[i]);
      end
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_strobes"}, int'({bus_req, busy, done, load_MAR, load_MDR, MDR_bus, CS}), 0);
    chk({name, "_r_nw"}, int'(R_NW), 1);
    chk({name, "_bus_free"}, int'(sysbus), int'(probe_val));
    chk({name, "_state"}, int'(state_dbg), 0);
  endtask

  // mode 0: grant held high; 1: random grant and stray starts;
  // 2: grant low for cycles 7..11 and a stray start in cycle 4.
  task automatic run_xfer(input logic [4:0] s, input logic [4:0] d, input logic [4:0] l,
                          input int mode, output int done_cyc);
    int cyc;
    @(negedge clock);
    start = 1'b1; src = s; dst = d; len = l; bus_gnt = 1'b1;
    @(negedge clock);
    start = 1'b0; src = 5'($urandom); dst = 5'($urandom); len = 5'($urandom);
    cyc = 1;
    done_cyc = -1;
    while (cyc < 400) begin
      if (done) begin done_cyc = cyc; break; end
      if (mode == 1) begin
        bus_gnt = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
      end else if (mode == 2) begin
        bus_gnt = !(cyc >= 7 && cyc <= 11);
        start = (cyc == 4);
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    bus_gnt = 1'b1;
    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("FAIL xfer_timeout got no done want done within 400 cycles");
    end
  endtask

  initial begin
    int dc;
    int k;
    n_reset = 1'b1;
    #2 n_reset = 1'b0;
    #1 check_reset("reset");
    #9 n_reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 32; i++) mem_write(5'(i), 8'($urandom));

    // Basic three-word copy
    mem_write(5'd2, 8'h11); mem_write(5'd3, 8'h22); mem_write(5'd4, 8'h33);
    run_xfer(5'd2, 5'd16, 5'd3, 0, dc);
    chk("t1_done_cycle", dc, 20);
    chk("t1_ram16", int'(env_ram[16]), 'h11);
    chk("t1_ram17", int'(env_ram[17]), 'h22);
    chk("t1_ram18", int'(env_ram[18]), 'h33);
    check_mem("t1");

    // Switch word at 30 copied to display word at 31
    mem_write(5'd30, 8'hA5);
    run_xfer(5'd30, 5'd31, 5'd1, 0, dc);
    chk("t2_done_cycle", dc, 8);
    chk("t2_seg0", int'(env_ram[31][3:0]), 'h5);
    chk("t2_seg1", int'(env_ram[31][7:4]), 'hA);
    check_mem("t2");

    // Address wrap with read-before-write
    mem_write(5'd31, 8'h7E); mem_write(5'd0, 8'h01);
    run_xfer(5'd31, 5'd0, 5'd2, 0, dc);
    chk("t3_done_cycle", dc, 14);
    chk("t3_ram0", int'(env_ram[0]), 'h7E);
    chk("t3_ram1", int'(env_ram[1]), 'h7E);
    check_mem("t3");

    // Zero length
    run_xfer(5'd9, 5'd12, 5'd0, 0, dc);
    chk("t4_done_cycle", dc, 1);
    check_mem("t4");

    // Grant withdrawn at the word boundary, stray start while busy
    run_xfer(5'd8, 5'd24, 5'd2, 2, dc);
    chk("t5_done_cycle", dc, 19);
    check_mem("t5");

    // Asynchronous reset during WR_MDR, then a clean transfer
    @(negedge clock);
    start = 1'b1; src = 5'd5; dst = 5'd20; len = 5'd2; bus_gnt = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (k < 20 && !(m_act && !m_wait && m_step == 4)) begin
      @(negedge clock);
      k++;
    end
    chk("t6_reached_wr_mdr", int'(k < 20), 1);
    #2 n_reset = 1'b0;
    #1 check_reset("t6_async");
    #1 n_reset = 1'b1;
    check_mem("t6_abort");
    run_xfer(5'd5, 5'd20, 5'd2, 0, dc);
    chk("t6_done_cycle", dc, 14);
    check_mem("t6");

    // Randomized transfers
    for (int t = 0; t < 10; t++) begin
      run_xfer(5'($urandom), 5'($urandom), 5'($urandom_range(0, 5)), 1, dc);
      check_mem("rand");
    end

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
